ospfb_pattern_src: RTL and testbench

- Parametrised multi-lane AXI-Stream test-pattern source; drives the ADC-side input of the OSPFB chain in place of the fixed single-impulse generator.
- Emits framed complex samples, SAMP_PER_CLK per beat, in four runtime-selectable modes: zero, impulse, constant, ramp.
- Honours tready backpressure, supports finite or continuous frame bursts, and stops only on frame boundaries.

---
 rtl/ospfb_pattern_src.sv | 167 ++++++++++++++++
 tb/tb_ospfb_pattern_src.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_pattern_src.sv
// ospfb_pattern_src: multi-lane AXI-Stream test-pattern source (zero/impulse/const/ramp)
// feeding the ADC-side input of the OSPFB chain. Frames are SAMP_PER_CLK samples per beat,
// bursts stop only on frame boundaries, and tready backpressure is honoured.
module ospfb_pattern_src #(
  parameter int unsigned SAMP_PER_CLK = 2,
  parameter int unsigned FFT_LEN      = 64,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned FRAME_CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [1:0]                        cfg_mode,
  input  logic [$clog2(FFT_LEN)-1:0]        cfg_pha,
  input  logic [WIDTH-1:0]                  cfg_amp,
  input  logic [FRAME_CNT_W-1:0]            cfg_frames,
  output logic [SAMP_PER_CLK*2*WIDTH-1:0]   m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic [FRAME_CNT_W-1:0]            frames_sent,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned NW    = $clog2(FFT_LEN);
  localparam int unsigned BEATS = FFT_LEN / SAMP_PER_CLK;
  localparam int unsigned BW    = $clog2(BEATS);
  localparam int unsigned DW    = SAMP_PER_CLK * 2 * WIDTH;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] MODE_ZERO    = 2'd0;
  localparam logic [1:0] MODE_IMPULSE = 2'd1;
  localparam logic [1:0] MODE_CONST   = 2'd2;
  localparam logic [1:0] MODE_RAMP    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [BW-1:0]          beat;
  logic [1:0]             mode_q;
  logic [NW-1:0]          pha_q;
  logic [WIDTH-1:0]       amp_q;
  logic [FRAME_CNT_W-1:0] frames_q;

  logic [BW-1:0]          beat_inc;
  logic [FRAME_CNT_W-1:0] fs_inc;
  logic                   xfer;

  // Pattern payload for one beat: lane k carries sample n = b*SAMP_PER_CLK + k as {im,re}.
  function automatic logic [DW-1:0] beat_data(
    input logic [BW-1:0]    b,
    input logic [1:0]       mode,
    input logic [NW-1:0]    pha,
    input logic [WIDTH-1:0] amp
  );
    logic [DW-1:0]    d;
    logic [NW-1:0]    n;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    d = '0;
    for (int unsigned k = 0; k < SAMP_PER_CLK; k++) begin
      n  = NW'(32'(b) * SAMP_PER_CLK + k);
      re = '0;
      im = '0;
      case (mode)
        MODE_ZERO:    re = '0;
        MODE_IMPULSE: if (n == pha) re = amp;
        MODE_CONST:   re = amp;
        MODE_RAMP: begin
          re = WIDTH'(n);
          im = '0 - WIDTH'(n);
        end
        default:      re = '0;
      endcase
      d[k*2*WIDTH +: 2*WIDTH] = {im, re};
    end
    return d;
  endfunction

  // Next-beat index, completed-frame count and handshake qualifier.
  assign beat_inc = beat + BW'(1);
  assign fs_inc   = frames_sent + FRAME_CNT_W'(1);
  assign xfer     = m_axis_tvalid && m_axis_tready;

  // Burst state machine with registered AXIS outputs and shadowed configuration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      beat          <= '0;
      mode_q        <= '0;
      pha_q         <= '0;
      amp_q         <= '0;
      frames_q      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frames_sent   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            mode_q        <= cfg_mode;
            pha_q         <= cfg_pha;
            amp_q         <= cfg_amp;
            frames_q      <= cfg_frames;
            frames_sent   <= '0;
            beat          <= '0;
            m_axis_tdata  <= beat_data('0, cfg_mode, cfg_pha, cfg_amp);
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            m_axis_tuser <= 1'b0;
            if (beat == LAST_BEAT) begin
              frames_sent <= fs_inc;
              if ((frames_q != '0) && (fs_inc == frames_q)) begin
                state         <= ST_DONE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tdata  <= '0;
                busy          <= 1'b0;
                done          <= 1'b1;
              end else if (!en) begin
                state         <= ST_IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tdata  <= '0;
                busy          <= 1'b0;
              end else begin
                beat         <= '0;
                m_axis_tdata <= beat_data('0, mode_q, pha_q, amp_q);
                m_axis_tlast <= 1'b0;
              end
            end else begin
              beat         <= beat_inc;
              m_axis_tdata <= beat_data(beat_inc, mode_q, pha_q, amp_q);
              m_axis_tlast <= (beat_inc == LAST_BEAT);
            end
          end
        end
        ST_DONE: begin
          if (!en) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ospfb_pattern_src.sv
// tb_ospfb_pattern_src: directed bursts with randomized backpressure and config values,
// checked against a sample-index arithmetic model of the pattern source.
module tb_ospfb_pattern_src;

  localparam int SPC   = 2;
  localparam int FFT   = 64;
  localparam int W     = 16;
  localparam int FCW   = 16;
  localparam int BEATS = FFT / SPC;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [1:0]        cfg_mode;
  logic [5:0]        cfg_pha;
  logic [W-1:0]      cfg_amp;
  logic [FCW-1:0]    cfg_frames;
  logic [63:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic [FCW-1:0]    frames_sent;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [63:0] q_data[$];
  bit          q_last[$];
  bit          q_user[$];

  bit          prev_stall;
  logic [63:0] prev_data;
  bit          prev_last;
  bit          prev_user;

  ospfb_pattern_src #(
    .SAMP_PER_CLK(SPC),
    .FFT_LEN     (FFT),
    .WIDTH       (W),
    .FRAME_CNT_W (FCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_mode     (cfg_mode),
    .cfg_pha      (cfg_pha),
    .cfg_amp      (cfg_amp),
    .cfg_frames   (cfg_frames),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .frames_sent  (frames_sent),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat payload from the sample-index rules, one lane at a time.
  function automatic logic [63:0] model_beat(input int mode, input int pha, input int amp, input int b);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < SPC; k++) begin
      int n;
      int re;
      int im;
      n  = b * SPC + k;
      re = 0;
      im = 0;
      if (mode == 1 && n == pha) re = amp;
      if (mode == 2) re = amp;
      if (mode == 3) begin
        re = n;
        im = -n;
      end
      d[k*2*W +: 2*W] = {W'(im), W'(re)};
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_user.delete();
    prev_stall = 1'b0;
  endtask

  // One clock with the given tready; checks stall stability and records transfers.
  task automatic cycle(input bit rdy);
    m_axis_tready = rdy;
    if (prev_stall) begin
      chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("stall_tdata", m_axis_tdata, prev_data);
      chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
      chk("stall_tuser", 64'(m_axis_tuser), 64'(prev_user));
    end
    prev_stall = m_axis_tvalid && !rdy;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    prev_user  = m_axis_tuser;
    if (m_axis_tvalid && rdy) begin
      q_data.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
      q_user.push_back(m_axis_tuser);
    end
    tick();
  endtask

  // Raise en in IDLE and check the first presented beat one cycle later.
  task automatic start_burst(input int mode, input int pha, input int amp);
    en = 1'b1;
    tick();
    chk("entry_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("entry_tuser", 64'(m_axis_tuser), 64'd1);
    chk("entry_busy", 64'(busy), 64'd1);
    chk("entry_done", 64'(done), 64'd0);
    chk("entry_frames_sent", 64'(frames_sent), 64'd0);
    chk("entry_tdata", m_axis_tdata, model_beat(mode, pha, amp, 0));
  endtask

  task automatic run_burst(input int max_cycles, input bit rnd, input int drop_at, input int stop_after);
    int c;
    c = 0;
    while (busy && c < max_cycles && !(stop_after >= 0 && q_data.size() >= stop_after)) begin
      if (drop_at >= 0 && q_data.size() >= drop_at) en = 1'b0;
      cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      c++;
    end
    if (stop_after < 0) chk("burst_end_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_beats(input int mode, input int pha, input int amp, input int exp_n);
    chk("beat_count", 64'(q_data.size()), 64'(exp_n));
    for (int i = 0; i < q_data.size() && i < exp_n; i++) begin
      int b;
      b = i % BEATS;
      chk($sformatf("tdata[%0d]", i), q_data[i], model_beat(mode, pha, amp, b));
      chk($sformatf("tlast[%0d]", i), 64'(q_last[i]), 64'(b == BEATS - 1));
      chk($sformatf("tuser[%0d]", i), 64'(q_user[i]), 64'(i == 0));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({tag, "_tuser"}, 64'(m_axis_tuser), 64'd0);
    chk({tag, "_tdata"}, m_axis_tdata, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_frames_sent"}, 64'(frames_sent), 64'd0);
  endtask

  initial begin
    int pha;
    int amp;
    int pha2;
    int amp2;
    logic [63:0] beat24;

    rst_n         = 1'b0;
    en            = 1'b0;
    m_axis_tready = 1'b0;
    cfg_mode      = 2'd0;
    cfg_pha       = '0;
    cfg_amp       = '0;
    cfg_frames    = '0;
    clear_q();

    // Reset state
    repeat (3) tick();
    check_idle_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Impulse, 3 frames, no backpressure
    cfg_mode   = 2'd1;
    cfg_pha    = 6'd49;
    cfg_amp    = 16'd64;
    cfg_frames = 16'd3;
    clear_q();
    start_burst(1, 49, 64);
    run_burst(1000, 1'b0, -1, -1);
    check_beats(1, 49, 64, 96);
    beat24 = q_data[24];
    chk("impulse_b24_lane1_re", 64'(beat24[47:32]), 64'd64);
    chk("impulse_b24_lane0", 64'(beat24[31:0]), 64'd0);
    chk("a_done", 64'(done), 64'd1);
    chk("a_frames_sent", 64'(frames_sent), 64'd3);
    chk("a_tvalid", 64'(m_axis_tvalid), 64'd0);

    // DONE holds while en stays high
    m_axis_tready = 1'b1;
    repeat (4) begin
      tick();
      chk("done_hold_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("done_hold_done", 64'(done), 64'd1);
      chk("done_hold_busy", 64'(busy), 64'd0);
    end
    en = 1'b0;
    tick();
    chk("done_exit_done", 64'(done), 64'd0);
    chk("done_exit_frames_sent", 64'(frames_sent), 64'd3);
    tick();

    // Ramp, single frame, random backpressure
    cfg_mode   = 2'd3;
    cfg_frames = 16'd1;
    clear_q();
    start_burst(3, 49, 64);
    run_burst(2000, 1'b1, -1, -1);
    check_beats(3, 49, 64, 32);
    chk("b_done", 64'(done), 64'd1);
    chk("b_frames_sent", 64'(frames_sent), 64'd1);
    en = 1'b0;
    tick();
    tick();

    // Constant -5, continuous, en dropped mid-frame three
    cfg_mode   = 2'd2;
    cfg_amp    = 16'(-5);
    cfg_frames = 16'd0;
    clear_q();
    start_burst(2, 49, -5);
    run_burst(3000, 1'b1, 80, -1);
    check_beats(2, 49, -5, 96);
    chk("c_done", 64'(done), 64'd0);
    chk("c_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("c_frames_sent", 64'(frames_sent), 64'd3);
    tick();

    // Config changes mid-burst only apply to the next burst
    pha  = int'($urandom_range(0, FFT - 1));
    amp  = int'($urandom_range(0, 65535)) - 32768;
    pha2 = pha ^ 5;
    amp2 = int'($urandom_range(0, 65535)) - 32768;
    cfg_mode   = 2'd1;
    cfg_pha    = 6'(pha);
    cfg_amp    = 16'(amp);
    cfg_frames = 16'd2;
    clear_q();
    start_burst(1, pha, amp);
    run_burst(2000, 1'b1, -1, 10);
    cfg_mode   = 2'd3;
    cfg_pha    = 6'(pha2);
    cfg_amp    = 16'(amp2);
    cfg_frames = 16'd1;
    run_burst(2000, 1'b1, -1, -1);
    check_beats(1, pha, amp, 64);
    chk("d_frames_sent", 64'(frames_sent), 64'd2);
    chk("d_done", 64'(done), 64'd1);
    en = 1'b0;
    tick();
    clear_q();
    start_burst(3, pha2, amp2);
    run_burst(2000, 1'b1, -1, -1);
    check_beats(3, pha2, amp2, 32);
    chk("d2_frames_sent", 64'(frames_sent), 64'd1);
    en = 1'b0;
    tick();

    // Reset during beat 10 of frame 1, then restart from beat 0
    cfg_mode   = 2'd2;
    cfg_amp    = 16'd1234;
    cfg_frames = 16'd0;
    clear_q();
    start_burst(2, pha2, 1234);
    run_burst(1000, 1'b0, -1, BEATS + 10);
    chk("pre_reset_count", 64'(q_data.size()), 64'(BEATS + 10));
    chk("pre_reset_frames_sent", 64'(frames_sent), 64'd1);
    cfg_frames    = 16'd1;
    m_axis_tready = 1'b1;
    rst_n         = 1'b0;
    tick();
    check_idle_zero("midreset");
    rst_n = 1'b1;
    clear_q();
    start_burst(2, pha2, 1234);
    run_burst(1000, 1'b0, -1, -1);
    check_beats(2, pha2, 1234, 32);
    chk("e_done", 64'(done), 64'd1);
    en = 1'b0;
    tick();
    chk("e_idle_done", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
